sid_audio_decimator: RTL

//  Downstream of the SID top: takes the stereo 18-bit SID mix sampled on ce_1m (~1 MHz)
//  and box-car averages it down to OUT_RATE (48 kHz) with a phase-accumulator decimator.

---
 rtl/sid_audio_pkg.sv | 29 ++
 rtl/sid_div_seq.sv | 65 ++++++
 rtl/sid_audio_decimator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sid_audio_pkg.sv
// Shared types, state encodings and saturation helper for the SID audio decimator.
package sid_audio_pkg;

    localparam int SAMPLE_W = 18;
    localparam int ACC_W    = SAMPLE_W + 5;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef logic [1:0] dec_state_t;
    localparam dec_state_t IDLE = 2'd0;
    localparam dec_state_t DIV  = 2'd1;
    localparam dec_state_t PUSH = 2'd2;
    localparam dec_state_t FILT = 2'd3;

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/sid_div_seq.sv
// Signed-by-unsigned restoring divider, one quotient bit per clk; done pulses DW clk after start.
// start is ignored while busy; quotient truncates toward zero and holds until the next start.
module sid_div_seq #(
    parameter int DW = 23,
    parameter int VW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [DW-1:0] dividend,
    input  logic [VW-1:0]        divisor,
    output logic                 busy,
    output logic                 done,
    output logic signed [DW-1:0] quotient
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] q;
    logic [VW-1:0] rem;
    logic [VW-1:0] dvs;
    logic          neg;
    logic [CW-1:0] steps;
    logic [VW:0]   trial;

    assign trial    = {rem, q[DW-1]};
    assign quotient = neg ? -$signed(q) : $signed(q);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg   <= 1'b0;
            steps <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                // Work on the magnitude; -(-2^(DW-1)) is still exact as an unsigned DW-bit value.
                neg   <= dividend[DW-1];
                q     <= dividend[DW-1] ? $unsigned(-dividend) : $unsigned(dividend);
                rem   <= '0;
                dvs   <= divisor;
                steps <= CW'(DW);
                busy  <= 1'b1;
            end else if (busy) begin
                if (trial >= {1'b0, dvs}) begin
                    rem <= VW'(trial - {1'b0, dvs});
                    q   <= {q[DW-2:0], 1'b1};
                end else begin
                    rem <= trial[VW-1:0];
                    q   <= {q[DW-2:0], 1'b0};
                end
                steps <= steps - CW'(1);
                if (steps == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sid_audio_decimator.sv
// Box-car decimates the stereo SID mix from ce_1m to OUT_RATE; window end to out_valid is W+7 clk (+1 with SID_DCBLOCK_EN).
// out_l/out_r hold while out_valid; a finished sample that finds the port still full is dropped and sets sticky overrun.
module sid_audio_decimator
    import sid_audio_pkg::*;
#(
    parameter int IN_RATE  = 985248,
    parameter int OUT_RATE = 48000,
    parameter int W        = SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce_1m,
    input  logic signed [W-1:0] audio_l,
    input  logic signed [W-1:0] audio_r,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_l,
    output logic signed [W-1:0] out_r,
    output logic                overrun
);

    localparam int         AW      = W + 5;
    localparam logic [4:0] CNT_MAX = 5'd31;

    logic signed [AW-1:0] acc_l, acc_r;
    logic signed [AW-1:0] sum_l, sum_r;
    logic signed [AW-1:0] q_l, q_r;
    logic signed [W-1:0]  res_l, res_r;
    logic [4:0]           cnt, cnt_nxt;
    logic [31:0]          phase, ph_add;
    logic                 win_end, start;
    logic                 busy_l, busy_r, done_l, done_r;
    dec_state_t           state;

    // The sample that closes a window is part of it, so the divider sees acc+sample and cnt+1.
    assign sum_l   = acc_l + AW'(audio_l);
    assign sum_r   = acc_r + AW'(audio_r);
    assign cnt_nxt = cnt + 5'd1;
    assign ph_add  = phase + 32'(OUT_RATE);
    assign win_end = ce_1m && ((ph_add >= 32'(IN_RATE)) || (cnt_nxt == CNT_MAX));
    assign start   = win_end && (state == IDLE) && !busy_l && !busy_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_l <= '0;
            acc_r <= '0;
            cnt   <= '0;
            phase <= '0;
        end else if (ce_1m) begin
            if (win_end) begin
                acc_l <= '0;
                acc_r <= '0;
                cnt   <= '0;
                phase <= (ph_add >= 32'(IN_RATE)) ? ph_add - 32'(IN_RATE) : ph_add;
            end else begin
                acc_l <= sum_l;
                acc_r <= sum_r;
                cnt   <= cnt_nxt;
                phase <= ph_add;
            end
        end
    end

    sid_div_seq #(.DW(AW), .VW(5)) u_div_l (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (sum_l),
        .divisor  (cnt_nxt),
        .busy     (busy_l),
        .done     (done_l),
        .quotient (q_l)
    );

    sid_div_seq #(.DW(AW), .VW(5)) u_div_r (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (sum_r),
        .divisor  (cnt_nxt),
        .busy     (busy_r),
        .done     (done_r),
        .quotient (q_r)
    );

`ifdef SID_DCBLOCK_EN
    localparam int YW = W + 2;

    logic signed [W-1:0]  x_l, x_r, y_l, y_r;
    logic signed [W-1:0]  x1_l, x1_r, y1_l, y1_r;
    logic signed [YW-1:0] yw_l, yw_r;

    // One-pole high-pass: y = x - x1 + y1 - y1/1024, pole just inside the unit circle.
    assign x_l  = W'(sat(32'(q_l), W));
    assign x_r  = W'(sat(32'(q_r), W));
    assign yw_l = YW'(x_l) - YW'(x1_l) + YW'(y1_l) - YW'(y1_l >>> 10);
    assign yw_r = YW'(x_r) - YW'(x1_r) + YW'(y1_r) - YW'(y1_r >>> 10);
    assign y_l  = W'(sat(32'(yw_l), W));
    assign y_r  = W'(sat(32'(yw_r), W));
`else
    assign res_l = W'(sat(32'(q_l), W));
    assign res_r = W'(sat(32'(q_r), W));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_l     <= '0;
            out_r     <= '0;
            overrun   <= 1'b0;
`ifdef SID_DCBLOCK_EN
            res_l     <= '0;
            res_r     <= '0;
            x1_l      <= '0;
            x1_r      <= '0;
            y1_l      <= '0;
            y1_r      <= '0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            // A window closing while the previous one is still in flight is lost.
            if (win_end && (state != IDLE))
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (start)
                        state <= DIV;
                end
                DIV: begin
                    if (done_l && done_r)
`ifdef SID_DCBLOCK_EN
                        state <= FILT;
`else
                        state <= PUSH;
`endif
                end
`ifdef SID_DCBLOCK_EN
                FILT: begin
                    res_l <= y_l;
                    res_r <= y_r;
                    x1_l  <= x_l;
                    x1_r  <= x_r;
                    y1_l  <= y_l;
                    y1_r  <= y_r;
                    state <= PUSH;
                end
`endif
                PUSH: begin
                    if (out_valid && !out_ready) begin
                        overrun <= 1'b1;
                    end else begin
                        out_l     <= res_l;
                        out_r     <= res_r;
                        out_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
